// File: rtl/mem_port_arbiter.sv
// Purpose : two-port (instruction fetch / data) arbiter in front of a single fixed-latency memory port.
// Latency : request seen in IDLE at edge T -> memory strobed for MEM_LAT cycles -> ack pulse after edge T+MEM_LAT.
// Backpr. : one access in flight; a requester holds req and payload until its ack; the loser simply waits.
//
// Ports:
//   clk, rst                              clock, synchronous active-low reset
//   if_req/if_addr -> if_rdata/if_ack     fetch port (read-only)
//   d_req/d_we/d_addr/d_wdata -> d_rdata/d_ack   data port (load/store)
//   mem_en/mem_we/mem_addr/mem_wdata <- mem_rdata memory side, rdata valid in the last access cycle
module mem_port_arbiter #(
  parameter int MEM_LAT = 2,   // legal range 1..15
  parameter int AW      = 32
) (
  input  logic          clk,
  input  logic          rst,
  // instruction fetch port
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [31:0]   if_rdata,
  output logic          if_ack,
  // data port
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic [31:0]   d_rdata,
  output logic          d_ack,
  // memory port
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_mem_lat
    $error("mem_port_arbiter: MEM_LAT must be in 1..15");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t     state;
  logic [3:0] cnt;       // remaining ACCESS cycles after the current one
  logic       last_gnt;  // 0 = fetch port won last, 1 = data port won last
  logic       cur_gnt;   // owner of the access in flight

  logic       any_req;
  logic       gnt_d;     // 1 when the data port wins this IDLE cycle

  // Round-robin: a lone requester wins; on a tie the port that did not
  // win last time goes next, so two busy ports strictly alternate.
  always_comb begin
    any_req = if_req | d_req;
    gnt_d   = d_req & (~if_req | ~last_gnt);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      last_gnt  <= 1'b1;   // fetch wins the first tie
      cur_gnt   <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      // acks are single-cycle pulses unless set below
      if_ack <= 1'b0;
      d_ack  <= 1'b0;

      case (state)
        IDLE: begin
          if (any_req) begin
            // Latch the winner's payload; later changes on the inputs are ignored.
            cur_gnt   <= gnt_d;
            last_gnt  <= gnt_d;
            mem_en    <= 1'b1;
            mem_we    <= gnt_d & d_we;
            mem_addr  <= gnt_d ? d_addr : if_addr;
            mem_wdata <= gnt_d ? d_wdata : 32'd0;
            cnt       <= CNT_INIT;
            state     <= ACCESS;
          end
        end

        ACCESS: begin
          if (cnt == 4'd0) begin
            // Last access cycle: mem_rdata is valid now.
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (cur_gnt) begin
              d_ack <= 1'b1;
              // stores leave the load data register untouched
              if (!mem_we) begin
                d_rdata <= mem_rdata;
              end
            end else begin
              if_ack   <= 1'b1;
              if_rdata <= mem_rdata;
            end
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        RESP: begin
          // The ack is visible this cycle; a request still held is re-arbitrated in IDLE.
          state <= IDLE;
        end

        default: begin
          state  <= IDLE;
          mem_en <= 1'b0;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

  // Only one port can own an access, so both acks can never pulse together.
  a_one_ack : assert property (@(posedge clk) disable iff (!rst) !(if_ack && d_ack));
  // A write strobe is only ever issued inside an access.
  a_we_en   : assert property (@(posedge clk) disable iff (!rst) mem_we |-> mem_en);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose : directed checks of mem_port_arbiter (MEM_LAT=2 instance plus a MEM_LAT=1 instance).
// Latency : inputs driven 1 time unit after a rising edge, outputs sampled 1 time unit after the next.
// Backpr. : requesters hold req until ack, then drop it.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam logic [31:0] DB = 32'hDEADBEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic [31:0]   mem_rdata;

  logic [31:0]   if_rdata, d_rdata, mem_wdata;
  logic          if_ack, d_ack, mem_en, mem_we;
  logic [AW-1:0] mem_addr;

  logic [31:0]   if_rdata1, d_rdata1, mem_wdata1;
  logic          if_ack1, d_ack1, mem_en1, mem_we1;
  logic [AW-1:0] mem_addr1;

  mem_port_arbiter #(.MEM_LAT(2), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.MEM_LAT(1), .AW(AW)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata1), .if_ack(if_ack1),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata1), .d_ack(d_ack1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] mem_rdata;
    logic        en;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ia;
    logic        da;
    logic [31:0] ird;
    logic [31:0] drd;
  } vec_t;

  vec_t tbl[14];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mkv(
    input logic r, input logic ir, input logic [31:0] ia_, input logic dr, input logic dw,
    input logic [31:0] da_, input logic [31:0] dwd, input logic [31:0] mr,
    input logic en, input logic we, input logic [31:0] ad, input logic [31:0] wd,
    input logic iak, input logic dak, input logic [31:0] ird, input logic [31:0] drd);
    vec_t v;
    v.rst = r; v.if_req = ir; v.if_addr = ia_; v.d_req = dr; v.d_we = dw;
    v.d_addr = da_; v.d_wdata = dwd; v.mem_rdata = mr;
    v.en = en; v.we = we; v.addr = ad; v.wdata = wd;
    v.ia = iak; v.da = dak; v.ird = ird; v.drd = drd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int c;
    rst = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; mem_rdata = DB;

    //               rst ifr if_addr     dr dw d_addr      d_wdata       mem_rdata       en we addr        wdata         ia da if_rdata      d_rdata
    tbl[0]  = mkv(0, 0, 32'h0,    0, 0, 32'h0,  32'h0,        DB,             0, 0, 32'h0,    32'h0,        0, 0, 32'h0,        32'h0);
    // fetch-only read
    tbl[1]  = mkv(1, 1, 32'h3000, 0, 0, 32'h0,  32'h0,        DB,             1, 0, 32'h3000, 32'h0,        0, 0, 32'h0,        32'h0);
    tbl[2]  = mkv(1, 1, 32'h3000, 0, 0, 32'h0,  32'h0,        DB,             1, 0, 32'h3000, 32'h0,        0, 0, 32'h0,        32'h0);
    tbl[3]  = mkv(1, 1, 32'h3000, 0, 0, 32'h0,  32'h0,        32'h01095021,   0, 0, 32'h3000, 32'h0,        1, 0, 32'h01095021, 32'h0);
    tbl[4]  = mkv(1, 0, 32'h0,    0, 0, 32'h0,  32'h0,        DB,             0, 0, 32'h3000, 32'h0,        0, 0, 32'h01095021, 32'h0);
    tbl[5]  = mkv(1, 0, 32'h0,    0, 0, 32'h0,  32'h0,        DB,             0, 0, 32'h3000, 32'h0,        0, 0, 32'h01095021, 32'h0);
    // store: d_rdata must not change
    tbl[6]  = mkv(1, 0, 32'h0,    1, 1, 32'h10, 32'h34567890, DB,             1, 1, 32'h10,   32'h34567890, 0, 0, 32'h01095021, 32'h0);
    tbl[7]  = mkv(1, 0, 32'h0,    1, 1, 32'h10, 32'h34567890, DB,             1, 1, 32'h10,   32'h34567890, 0, 0, 32'h01095021, 32'h0);
    tbl[8]  = mkv(1, 0, 32'h0,    1, 1, 32'h10, 32'h34567890, 32'hCAFEF00D,   0, 0, 32'h10,   32'h34567890, 0, 1, 32'h01095021, 32'h0);
    tbl[9]  = mkv(1, 0, 32'h0,    0, 0, 32'h0,  32'h0,        DB,             0, 0, 32'h10,   32'h34567890, 0, 0, 32'h01095021, 32'h0);
    // load whose payload changes one cycle after grant
    tbl[10] = mkv(1, 0, 32'h0,    1, 0, 32'h18, 32'h0,        DB,             1, 0, 32'h18,   32'h0,        0, 0, 32'h01095021, 32'h0);
    tbl[11] = mkv(1, 0, 32'h0,    1, 1, 32'h1C, 32'h11111111, DB,             1, 0, 32'h18,   32'h0,        0, 0, 32'h01095021, 32'h0);
    tbl[12] = mkv(1, 0, 32'h0,    1, 1, 32'h1C, 32'h11111111, 32'hAABBCCDD,   0, 0, 32'h18,   32'h0,        0, 1, 32'h01095021, 32'hAABBCCDD);
    tbl[13] = mkv(1, 0, 32'h0,    0, 0, 32'h0,  32'h0,        DB,             0, 0, 32'h18,   32'h0,        0, 0, 32'h01095021, 32'hAABBCCDD);

    for (int i = 0; i < 14; i++) begin
      rst = tbl[i].rst; if_req = tbl[i].if_req; if_addr = tbl[i].if_addr;
      d_req = tbl[i].d_req; d_we = tbl[i].d_we; d_addr = tbl[i].d_addr;
      d_wdata = tbl[i].d_wdata; mem_rdata = tbl[i].mem_rdata;
      tick();
      chk($sformatf("row%0d mem_en", i),    32'(mem_en),   32'(tbl[i].en));
      chk($sformatf("row%0d mem_we", i),    32'(mem_we),   32'(tbl[i].we));
      chk($sformatf("row%0d mem_addr", i),  mem_addr,      tbl[i].addr);
      chk($sformatf("row%0d mem_wdata", i), mem_wdata,     tbl[i].wdata);
      chk($sformatf("row%0d if_ack", i),    32'(if_ack),   32'(tbl[i].ia));
      chk($sformatf("row%0d d_ack", i),     32'(d_ack),    32'(tbl[i].da));
      chk($sformatf("row%0d if_rdata", i),  if_rdata,      tbl[i].ird);
      chk($sformatf("row%0d d_rdata", i),   d_rdata,       tbl[i].drd);
    end

    // Tie after reset with both ports held: IF, D, IF, D, IF, D at MEM_LAT+2 cycles each.
    do_reset();
    if_req = 1'b1; if_addr = 32'h100; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_wdata = '0;
    for (int i = 0; i < 6; i++) begin
      logic is_d;
      is_d = (i % 2) == 1;
      mem_rdata = 32'h1000 + 32'(i);
      c = 0;
      do begin tick(); c++; end while (!mem_en && c < 10);
      chk($sformatf("tie%0d gap", i), 32'(c), (i == 0) ? 32'd1 : 32'd2);
      chk($sformatf("tie%0d addr", i), mem_addr, is_d ? 32'h200 : 32'h100);
      k = 0;
      do begin tick(); k++; end while (!(if_ack || d_ack) && k < 10);
      chk($sformatf("tie%0d lat", i), 32'(k), 32'd2);
      chk($sformatf("tie%0d acks", i), 32'({if_ack, d_ack}), is_d ? 32'd1 : 32'd2);
      chk($sformatf("tie%0d rdata", i), is_d ? d_rdata : if_rdata, 32'h1000 + 32'(i));
    end
    if_req = 1'b0; d_req = 1'b0;
    tick(); tick();

    // Reset in the first ACCESS cycle aborts; the held fetch is then served normally.
    do_reset();
    if_req = 1'b1; if_addr = 32'h4000; mem_rdata = 32'h55AA55AA;
    tick();
    chk("rma granted", 32'(mem_en), 32'd1);
    rst = 1'b0;
    tick();
    chk("rma en_off", 32'(mem_en), 32'd0);
    chk("rma no_ack", 32'({if_ack, d_ack}), 32'd0);
    rst = 1'b1;
    tick();
    chk("rma regrant", 32'(mem_en), 32'd1);
    chk("rma addr", mem_addr, 32'h4000);
    k = 0;
    do begin tick(); k++; end while (!(if_ack || d_ack) && k < 10);
    chk("rma lat", 32'(k), 32'd2);
    chk("rma if_ack", 32'(if_ack), 32'd1);
    chk("rma if_rdata", if_rdata, 32'h55AA55AA);
    if_req = 1'b0;
    tick(); tick();

    // MEM_LAT=1 load.
    do_reset();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1C; mem_rdata = 32'h12345678;
    tick();
    chk("l1 mem_en", 32'(mem_en1), 32'd1);
    chk("l1 mem_addr", mem_addr1, 32'h1C);
    k = 0;
    do begin tick(); k++; end while (!(if_ack1 || d_ack1) && k < 10);
    chk("l1 lat", 32'(k), 32'd1);
    chk("l1 d_ack", 32'(d_ack1), 32'd1);
    chk("l1 mem_en_off", 32'(mem_en1), 32'd0);
    chk("l1 d_rdata", d_rdata1, 32'h12345678);
    d_req = 1'b0;
    tick();
    chk("l1 ack_pulse", 32'(d_ack1), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
